mult8_seq_ctrl: RTL and testbench
=================================

// Module: mult8_seq_ctrl
// PURPOSE
//  Sequencer that time-shares one 4x4 combinational array multiplier to form 8x8 unsigned products.
//  Accepts one operand pair over a valid/ready handshake and issues the four nibble partial
//  products to the multiplier in fixed order, one per cycle. Accumulates them with shifts into a
//  16-bit result, which it presents over a valid/ready handshake. Sits between top-level I/O
//  capture and the existing array-multiplier datapath.
// PARAMETERS
//  SKIP_ZERO   1  1: zero operand bypasses the CALC sequence (latency 1); 0: always run 4 steps
//  OPS_CNT_W   8  width of the wrapping completed-operation counter
// PORTS
//  clk        in   1          clock, all state updates on rising edge
//  rst        in   1          asynchronous, active-high reset
//  in_valid   in   1          operand pair a/b valid
//  in_ready   out  1          block can accept an operand pair
//  a          in   8          multiplicand, unsigned
//  b          in   8          multiplier, unsigned
//  abort      in   1          synchronous abort of the current operation
//  out_valid  out  1          product valid, held until taken
//  out_ready  in   1          consumer takes product
//  product    out  16         a*b, unsigned
//  busy       out  1          state != IDLE
//  ops_done   out  OPS_CNT_W  count of products handed off (out_valid&&out_ready), wraps
// BEHAVIOUR
//  One clock (clk). Reset is asynchronous, active-high (rst).
//  Reset values: state=IDLE, in_ready=1, out_valid=0, product=0, busy=0, ops_done=0, step=0.
//  States: IDLE, CALC, DONE.
//  - IDLE: in_ready=1. On in_valid&&in_ready, register a/b, clear acc and set step=0.
//    If SKIP_ZERO=1 and (a==0 || b==0), go to DONE with product=0. Otherwise go to CALC.
//  - CALC: in_ready=0. Each cycle the multiplier receives (m,q) = nibble pair selected by step.
//    acc <= acc + (pp4x8 << shift). Step order is fixed:
//      step0 aL*bL shift 0; step1 aH*bL shift 4; step2 aL*bH shift 4; step3 aH*bH shift 8.
//    step increments 0..3. On the step3 edge: product <= final acc, state <= DONE, out_valid <= 1.
//  - DONE: out_valid=1, product stable. On out_valid&&out_ready: out_valid<=0, ops_done+=1,
//    state<=IDLE. No new operand is accepted in the same edge; in_ready returns the cycle after.
//  Latency: accept edge to out_valid high = 4 cycles (1 cycle for the zero bypass).
//  Throughput: one product per >=6 cycles with out_ready tied high.
//  Width rules:
//  - Partial products are 8 bits. acc is 16 bits; max 255*255=65025, so no overflow occurs.
//  - product updates only on entry to DONE and is held otherwise, including after handoff.
//  abort:
//  - In CALC: go to IDLE next edge. out_valid stays 0, ops_done unchanged, product keeps its old value.
//  - In DONE: drop out_valid and go to IDLE; no count.
//  - In IDLE: ignored. abort takes priority over an in_valid handshake in the same cycle.
//  Async reset mid-CALC/DONE: returns to reset values immediately; any in-flight result is lost.
//  ops_done wraps from 2^OPS_CNT_W-1 to 0 silently.
//  in_valid while busy: ignored, and the operands are not sampled; the producer must hold them.
// STRUCTURE
//  Shared package mult_seq_pkg:
//  - state encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2)
//  - step-to-shift table {0,4,4,8} and nibble-select constants.
//  One sub-module: mult4x4_array (combinational 4x4 unsigned array multiplier, m[3:0], q[3:0] ->
//  p[7:0]), instantiated once. The controller owns the FSM, step counter, nibble muxes,
//  accumulator and ops counter.
// TESTING
//  1. a=8'hFF, b=8'hFF, out_ready=1 -> out_valid 4 cycles after accept, product=16'hFE01,
//     ops_done=1.
//  2. a=8'h00, b=8'h5A, SKIP_ZERO=1 -> out_valid 1 cycle after accept, product=0.
//     Same with SKIP_ZERO=0 -> product=0 after 4 cycles.
//  3. a=8'h3C, b=8'hA7, out_ready=0 for 10 cycles -> product=16'h2724 held stable,
//     in_ready=0 throughout; handoff -> in_ready=1 the next cycle.
//  4. a=8'h12, b=8'h34, abort at step2 -> IDLE next cycle, out_valid never asserts,
//     ops_done unchanged.
//  5. Assert rst asynchronously mid-CALC -> all outputs at reset values before the next clk edge;
//     next op a=8'h0F, b=8'h10 -> product=16'h00F0.
//  6. Preload 255 ops, then one more (a=2, b=3, product=6) -> ops_done wraps to 0.
//     Random 1000-pair sweep vs a*b model.

Source files
------------

// File: rtl/mult_seq_pkg.sv
// Shared definitions for the sequential 8x8 multiplier controller.
// - state_e    : controller FSM encoding
// - ASelHi/BSelHi : per-step nibble select masks (bit n set = high nibble at step n)
// - step_shift : accumulator shift for each partial-product step
package mult_seq_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;

    // Step order: 0 aL*bL, 1 aH*bL, 2 aL*bH, 3 aH*bH
    localparam logic [3:0] ASelHi = 4'b1010;
    localparam logic [3:0] BSelHi = 4'b1100;

    function automatic logic [3:0] step_shift(input logic [1:0] step);
        logic [3:0] sh;
        unique case (step)
            2'd0:    sh = 4'd0;
            2'd1:    sh = 4'd4;
            2'd2:    sh = 4'd4;
            default: sh = 4'd8;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/mult8_seq_ctrl_if.sv
// Handshake bundle for mult8_seq_ctrl.
// Input side : in_valid/in_ready with operands a, b; abort
// Output side: out_valid/out_ready with product; busy and ops_done status
// slave modport is the controller view, master is the producer/consumer view.
interface mult8_seq_ctrl_if #(
    parameter int unsigned OPS_CNT_W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [7:0]           a;
    logic [7:0]           b;
    logic                 abort;
    logic                 out_valid;
    logic                 out_ready;
    logic [15:0]          product;
    logic                 busy;
    logic [OPS_CNT_W-1:0] ops_done;

    modport slave (
        input  in_valid, a, b, abort, out_ready,
        output in_ready, out_valid, product, busy, ops_done
    );

    modport master (
        output in_valid, a, b, abort, out_ready,
        input  in_ready, out_valid, product, busy, ops_done
    );
endinterface

// File: rtl/mult4x4_array.sv
// Combinational 4x4 unsigned array multiplier.
// Ports: m_i[3:0] multiplicand, q_i[3:0] multiplier, p_o[7:0] product.
module mult4x4_array (
    input  logic [3:0] m_i,
    input  logic [3:0] q_i,
    output logic [7:0] p_o
);
    logic [7:0] sum;

    // Each multiplier bit gates one shifted row of the multiplicand.
    always_comb begin
        sum = '0;
        for (int i = 0; i < 4; i++) begin
            if (q_i[i]) begin
                sum = sum + ({4'b0000, m_i} << i);
            end
        end
    end

    assign p_o = sum;
endmodule

// File: rtl/mult8_seq_ctrl.sv
// Sequencer forming 8x8 unsigned products with one shared 4x4 array multiplier.
// Ports: clk, rst (async, active-high); bus_if (slave) carries the operand handshake
// (in_valid/in_ready, a, b), abort, the result handshake (out_valid/out_ready, product),
// busy and the wrapping completed-operation counter ops_done.
// Parameters: SKIP_ZERO bypasses the four-step sequence for a zero operand;
// OPS_CNT_W sets the width of ops_done.
module mult8_seq_ctrl
    import mult_seq_pkg::*;
#(
    parameter bit          SKIP_ZERO = 1'b1,
    parameter int unsigned OPS_CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    mult8_seq_ctrl_if.slave         bus_if
);
    state_e               state_q, state_d;
    logic [1:0]           step_q, step_d;
    logic [7:0]           a_q, a_d;
    logic [7:0]           b_q, b_d;
    logic [15:0]          acc_q, acc_d;
    logic [15:0]          product_q, product_d;
    logic                 out_valid_q, out_valid_d;
    logic [OPS_CNT_W-1:0] ops_q, ops_d;

    logic [3:0]  m, q;
    logic [7:0]  pp;
    logic [15:0] pp_sh;
    logic [15:0] acc_sum;

    // Nibble muxes feeding the shared multiplier
    always_comb begin
        m       = ASelHi[step_q] ? a_q[7:4] : a_q[3:0];
        q       = BSelHi[step_q] ? b_q[7:4] : b_q[3:0];
        pp_sh   = {8'h00, pp} << step_shift(step_q);
        acc_sum = acc_q + pp_sh;
    end

    mult4x4_array u_mult (
        .m_i (m),
        .q_i (q),
        .p_o (pp)
    );

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        product_d   = product_q;
        out_valid_d = out_valid_q;
        ops_d       = ops_q;

        unique case (state_q)
            StIdle: begin
                // abort wins over a simultaneous handshake
                if (bus_if.in_valid && !bus_if.abort) begin
                    a_d    = bus_if.a;
                    b_d    = bus_if.b;
                    acc_d  = '0;
                    step_d = 2'd0;
                    if (SKIP_ZERO && (bus_if.a == 8'h00 || bus_if.b == 8'h00)) begin
                        state_d     = StDone;
                        product_d   = '0;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                if (bus_if.abort) begin
                    state_d = StIdle;
                    step_d  = 2'd0;
                end else begin
                    acc_d  = acc_sum;
                    step_d = step_q + 2'd1;
                    if (step_q == 2'd3) begin
                        product_d   = acc_sum;
                        out_valid_d = 1'b1;
                        state_d     = StDone;
                    end
                end
            end
            StDone: begin
                if (bus_if.abort) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end else if (bus_if.out_ready) begin
                    out_valid_d = 1'b0;
                    ops_d       = ops_q + OPS_CNT_W'(1);
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d     = StIdle;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            step_q      <= 2'd0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
            ops_q       <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            product_q   <= product_d;
            out_valid_q <= out_valid_d;
            ops_q       <= ops_d;
        end
    end

    assign bus_if.in_ready  = (state_q == StIdle);
    assign bus_if.busy      = (state_q != StIdle);
    assign bus_if.out_valid = out_valid_q;
    assign bus_if.product   = product_q;
    assign bus_if.ops_done  = ops_q;
endmodule

// File: tb/tb_mult8_seq_ctrl.sv
module tb_mult8_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mult8_seq_ctrl_if #(.OPS_CNT_W(8)) if0 ();
    mult8_seq_ctrl_if #(.OPS_CNT_W(8)) if1 ();

    mult8_seq_ctrl #(.SKIP_ZERO(1'b1), .OPS_CNT_W(8)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (if0.slave)
    );

    mult8_seq_ctrl #(.SKIP_ZERO(1'b0), .OPS_CNT_W(8)) u_dut_ns (
        .clk    (clk),
        .rst    (rst),
        .bus_if (if1.slave)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  exp_ops  = 8'd0;
    logic [15:0] last_prod = 16'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: samples just after the falling edge, so a handshake it sees
    // completes on the next rising edge.
    always begin
        logic [15:0] e;
        @(negedge clk);
        #1;
        if (!rst && if0.out_valid && if0.out_ready && !if0.abort) begin
            if (exp_q.size() == 0) begin
                check("unexpected_product", 32'(if0.product), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("product", 32'(if0.product), 32'(e));
                last_prod = e;
            end
            check("ops_done", 32'(if0.ops_done), 32'(exp_ops));
            exp_ops = exp_ops + 8'd1;
        end
    end

    // One operation on the SKIP_ZERO=1 instance; hold = cycles out_ready stays low.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input int hold);
        int          lat;
        logic [15:0] prod;
        prod = 16'(av) * 16'(bv);
        @(negedge clk);
        if0.a         = av;
        if0.b         = bv;
        if0.in_valid  = 1'b1;
        if0.out_ready = (hold == 0);
        lat = 0;
        while (!if0.in_ready && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("accept_ready", 32'(if0.in_ready), 32'd1);
        exp_q.push_back(prod);
        @(negedge clk);
        // Operands must already be captured.
        if0.in_valid = 1'b0;
        if0.a        = 8'($urandom);
        if0.b        = 8'($urandom);
        lat = 0;
        while (!if0.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        // Edges after the accept edge: zero bypass shows out_valid in the very next cycle.
        check("latency", 32'(lat), (av == 8'd0 || bv == 8'd0) ? 32'd0 : 32'd4);
        if (hold > 0) begin
            repeat (hold) begin
                check("held_product", 32'(if0.product), 32'(prod));
                check("held_in_ready", 32'(if0.in_ready), 32'd0);
                check("held_valid", 32'(if0.out_valid), 32'd1);
                @(negedge clk);
            end
            if0.out_ready = 1'b1;
        end
        @(negedge clk);
        check("in_ready_after", 32'(if0.in_ready), 32'd1);
        check("valid_after", 32'(if0.out_valid), 32'd0);
        check("product_kept", 32'(if0.product), 32'(prod));
    endtask

    task automatic flush_model();
        exp_q.delete();
        exp_ops   = 8'd0;
        last_prod = 16'd0;
    endtask

    initial begin
        int lat;
        if0.in_valid = 1'b0; if0.a = '0; if0.b = '0; if0.abort = 1'b0; if0.out_ready = 1'b1;
        if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.abort = 1'b0; if1.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(if0.in_ready), 32'd1);
        check("rst_out_valid", 32'(if0.out_valid), 32'd0);
        check("rst_product", 32'(if0.product), 32'd0);
        check("rst_busy", 32'(if0.busy), 32'd0);
        check("rst_ops", 32'(if0.ops_done), 32'd0);
        rst = 1'b0;

        // 1: max operands
        run_op(8'hFF, 8'hFF, 0);
        check("ops_after_first", 32'(if0.ops_done), 32'd1);

        // 2: zero bypass, then same pair on the non-skipping instance
        run_op(8'h00, 8'h5A, 0);
        @(negedge clk);
        if1.a = 8'h00; if1.b = 8'h5A; if1.in_valid = 1'b1;
        @(negedge clk);
        if1.in_valid = 1'b0;
        lat = 0;
        while (!if1.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("ns_latency", 32'(lat), 32'd4);
        check("ns_product", 32'(if1.product), 32'd0);
        @(negedge clk);
        check("ns_ops", 32'(if1.ops_done), 32'd1);
        check("ns_in_ready", 32'(if1.in_ready), 32'd1);

        // 3: consumer stalls for 10 cycles
        run_op(8'h3C, 8'hA7, 10);

        // 4: abort during step 2
        @(negedge clk);
        if0.a = 8'h12; if0.b = 8'h34; if0.in_valid = 1'b1;
        @(negedge clk);             // step 0
        if0.in_valid = 1'b0;
        check("abort_busy_calc", 32'(if0.busy), 32'd1);
        @(negedge clk);             // step 1
        @(negedge clk);             // step 2
        if0.abort = 1'b1;
        @(negedge clk);
        if0.abort = 1'b0;
        check("abort_idle", 32'(if0.busy), 32'd0);
        check("abort_in_ready", 32'(if0.in_ready), 32'd1);
        repeat (6) begin
            check("abort_no_valid", 32'(if0.out_valid), 32'd0);
            @(negedge clk);
        end
        check("abort_ops", 32'(if0.ops_done), 32'(exp_ops));
        check("abort_product", 32'(if0.product), 32'(last_prod));

        // abort in IDLE blocks a simultaneous handshake
        if0.a = 8'h11; if0.b = 8'h22; if0.in_valid = 1'b1; if0.abort = 1'b1;
        @(negedge clk);
        if0.in_valid = 1'b0; if0.abort = 1'b0;
        check("idle_abort_busy", 32'(if0.busy), 32'd0);

        // 5: asynchronous reset mid-CALC
        if0.a = 8'h55; if0.b = 8'h77; if0.in_valid = 1'b1;
        @(negedge clk);
        if0.in_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(if0.busy), 32'd0);
        check("arst_in_ready", 32'(if0.in_ready), 32'd1);
        check("arst_valid", 32'(if0.out_valid), 32'd0);
        check("arst_product", 32'(if0.product), 32'd0);
        check("arst_ops", 32'(if0.ops_done), 32'd0);
        flush_model();
        @(negedge clk);
        rst = 1'b0;
        run_op(8'h0F, 8'h10, 0);

        // 6: counter wrap, then random sweep
        for (int i = 0; i < 254; i++) begin
            run_op(8'($urandom), 8'($urandom), 0);
        end
        check("ops_255", 32'(if0.ops_done), 32'd255);
        run_op(8'd2, 8'd3, 0);
        check("ops_wrap", 32'(if0.ops_done), 32'd0);

        for (int i = 0; i < 1000; i++) begin
            logic [7:0] ra, rb;
            ra = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
            rb = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
            run_op(ra, rb, (i % 7 == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        repeat (2) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
